fec_cc_encoder: RTL and testbench

- Rate-1/2 tail-biting convolutional encoder (802.16 CC, K=7, G1=171 oct, G2=133 oct).
- Sits directly upstream of interleaver_top. It takes the randomized serial bitstream and produces a serial coded stream of Ncbps=192 bits per block.
- Its valid_out/data_out drive the interleaver's valid_in/data_in.
- Two-bank input buffer: one 96-bit block is collected while the previous block is encoded.

---
 rtl/fec_cc_encoder.sv | 142 ++++++++++++++
 tb/tb_fec_cc_encoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fec_cc_encoder.sv
// Rate-1/2 tail-biting convolutional encoder (K=7) with a two-bank input buffer.
// Optional `define FEC_BLOCK_CNT_EN adds a 16-bit count of encoded blocks on block_cnt.
module fec_cc_encoder #(
    parameter int unsigned Nbits = 96,
    parameter logic [6:0]  G1    = 7'o171,
    parameter logic [6:0]  G2    = 7'o133
) (
    input  logic        clk,
    input  logic        reset_N,
    input  logic        data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        data_out,
    output logic        valid_out,
    input  logic        ready_in
`ifdef FEC_BLOCK_CNT_EN
    ,
    output logic [15:0] block_cnt
`endif
);

    localparam int unsigned IW = $clog2(Nbits);

    // Generator MSB is the undelayed input; re-order so tap bit k means delay k.
    localparam logic [6:0] T1 = {G1[0], G1[1], G1[2], G1[3], G1[4], G1[5], G1[6]};
    localparam logic [6:0] T2 = {G2[0], G2[1], G2[2], G2[3], G2[4], G2[5], G2[6]};

    typedef enum logic [1:0] {IDLE, PRELOAD, ENCODE} state_t;

    state_t           state, state_nx;
    logic [Nbits-1:0] bank [2];
    logic [Nbits-1:0] cur;
    logic [1:0]       full;
    logic             wr_bank, rd_bank;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             run;
    logic             phase;
    logic [6:1]       sr, sr_pre, sr_shift;
    logic             u, u_next;
    logic             accept, wr_last, xfer, rd_last, done;

    function automatic logic cc_bit(input logic [6:0] taps, input logic ui, input logic [6:1] s);
        return ^({s, ui} & taps);
    endfunction

    assign cur       = bank[rd_bank];
    assign u         = cur[rd_idx];
    assign u_next    = cur[rd_idx + 1'b1];
    assign sr_pre    = {cur[Nbits-6], cur[Nbits-5], cur[Nbits-4],
                        cur[Nbits-3], cur[Nbits-2], cur[Nbits-1]};
    assign sr_shift  = {sr[5:1], u};

    assign ready_out = run & ~full[wr_bank];
    assign accept    = valid_in & ready_out;
    assign wr_last   = (wr_idx == IW'(Nbits - 1));
    assign xfer      = valid_out & ready_in;
    assign rd_last   = (rd_idx == IW'(Nbits - 1));
    assign done      = (state == ENCODE) & xfer & phase & rd_last;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_nx = PRELOAD;
            PRELOAD: state_nx = ENCODE;
            ENCODE:  if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bank storage needs no reset: the full flags decide what is meaningful.
    always_ff @(posedge clk) begin
        if (accept) bank[wr_bank][wr_idx] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            run     <= 1'b0;
            full    <= '0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_idx        <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            // Never the bank being filled, so both flag updates land.
            if (done) full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            phase     <= 1'b0;
            sr        <= '0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
        end else if (state == PRELOAD) begin
            sr        <= sr_pre;
            rd_idx    <= '0;
            phase     <= 1'b0;
            data_out  <= cc_bit(T1, cur[0], sr_pre);
            valid_out <= 1'b1;
        end else if (state == ENCODE && xfer) begin
            if (!phase) begin
                data_out <= cc_bit(T2, u, sr);
                phase    <= 1'b1;
            end else if (rd_last) begin
                rd_bank   <= ~rd_bank;
                rd_idx    <= '0;
                phase     <= 1'b0;
                data_out  <= 1'b0;
                valid_out <= 1'b0;
            end else begin
                sr       <= sr_shift;
                rd_idx   <= rd_idx + 1'b1;
                phase    <= 1'b0;
                data_out <= cc_bit(T1, u_next, sr_shift);
            end
        end
    end

`ifdef FEC_BLOCK_CNT_EN
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N)  block_cnt <= '0;
        else if (done) block_cnt <= block_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fec_cc_encoder.sv
// Self-checking bench for fec_cc_encoder: random and directed blocks scored against
// a circular-index tail-biting reference model.
module tb_fec_cc_encoder;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    logic data_in = 1'b0;
    logic valid_in = 1'b0;
    logic ready_in = 1'b0;
    logic ready_out, data_out, valid_out;
`ifdef FEC_BLOCK_CNT_EN
    logic [15:0] block_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic got[$];
    int   tcyc[$];
    int   acc_cyc[$];
    int   first_valid;
    int   stall_bad;
    bit   stalled;

    fec_cc_encoder #(.Nbits(96), .G1(7'o171), .G2(7'o133)) dut (
        .clk       (clk),
        .reset_N   (reset_N),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
`ifdef FEC_BLOCK_CNT_EN
        ,
        .block_cnt (block_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Output bit k in time order: X_i at 2i, Y_i at 2i+1; history wraps around the block.
    function automatic logic [191:0] ref_encode(input logic [95:0] b);
        logic [191:0] r;
        for (int i = 0; i < 96; i++) begin
            r[2*i]   = b[i] ^ b[(i+95)%96] ^ b[(i+94)%96] ^ b[(i+93)%96] ^ b[(i+90)%96];
            r[2*i+1] = b[i] ^ b[(i+94)%96] ^ b[(i+93)%96] ^ b[(i+91)%96] ^ b[(i+90)%96];
        end
        return r;
    endfunction

    function automatic logic [191:0] got_block(input int off);
        logic [191:0] r;
        for (int k = 0; k < 192; k++)
            r[k] = (off + k < got.size()) ? got[off + k] : 1'bx;
        return r;
    endfunction

    function automatic logic [95:0] rand_block();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic send_block(input logic [95:0] b);
        bit ok;
        int w;
        for (int i = 0; i < 96; i++) begin
            data_in  = b[i];
            valid_in = 1'b1;
            ok = 1'b0;
            w  = 0;
            while (!ok && w < 2000) begin
                @(negedge clk);
                ok = ready_out;
                @(posedge clk);
                #1;
                w++;
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: bit %0d never accepted, ready_out=%b required 1", i, ready_out);
                valid_in = 1'b0;
                return;
            end
            acc_cyc.push_back(cyc);
            if (w > 1) stalled = 1'b1;
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    // mode 0: ready_in always 1; mode 1: pattern 1,0,0; mode 2: random.
    task automatic collect(input int n, input int mode, input int budget);
        int   k;
        logic held_v, held_d;
        k = 0;
        held_v = 1'b0;
        held_d = 1'b0;
        got.delete();
        tcyc.delete();
        first_valid = -1;
        stall_bad = 0;
        while (got.size() < n && k < budget) begin
            case (mode)
                0:       ready_in = 1'b1;
                1:       ready_in = (k % 3 == 0);
                default: ready_in = 1'($urandom % 2);
            endcase
            @(negedge clk);
            if (held_v && (valid_out !== 1'b1 || data_out !== held_d)) stall_bad++;
            if (valid_out === 1'b1 && first_valid < 0) first_valid = cyc;
            if (valid_out === 1'b1 && ready_in) begin
                got.push_back(data_out);
                tcyc.push_back(cyc);
                held_v = 1'b0;
            end else begin
                held_v = (valid_out === 1'b1);
                held_d = data_out;
            end
            @(posedge clk);
            #1;
            k++;
        end
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_N = 1'b0;
        #3;
        checks++;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready_out: got %b expected 0", ready_out); end
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        checks++;
        if (data_out !== 1'b0) begin failures++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
        @(posedge clk);
        @(negedge clk);
        reset_N = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL release_ready_early: got %b expected 0", ready_out); end
        @(posedge clk);
        #1;
        checks++;
        if (ready_out !== 1'b1) begin failures++; $display("FAIL release_ready_first_edge: got %b expected 1", ready_out); end
    endtask

    task automatic test_zero_block();
        logic [95:0] b;
        b = '0;
        acc_cyc.delete();
        fork
            send_block(b);
            collect(192, 0, 1000);
        join
        checks++;
        if (got_block(0) !== ref_encode(b))
            begin failures++; $display("FAIL zero_block: got %h expected %h", got_block(0), ref_encode(b)); end
        checks++;
        if (tcyc.size() != 192 || tcyc[191] - tcyc[0] != 191)
            begin failures++; $display("FAIL zero_continuous: span %0d expected 191", tcyc.size() == 192 ? tcyc[191] - tcyc[0] : -1); end
        checks++;
        if (acc_cyc.size() != 96 || first_valid != acc_cyc[95] + 2)
            begin failures++; $display("FAIL latency: valid at cycle %0d expected %0d", first_valid, acc_cyc.size() == 96 ? acc_cyc[95] + 2 : -1); end
    endtask

    task automatic test_impulse();
        logic [95:0] b;
        logic [13:0] pat, g14;
        b = '0;
        b[0] = 1'b1;
        pat = 14'b11_10_11_11_00_01_11;
        fork
            send_block(b);
            collect(192, 0, 1000);
        join
        for (int k = 0; k < 14; k++) g14[13-k] = (k < got.size()) ? got[k] : 1'bx;
        checks++;
        if (g14 !== pat) begin failures++; $display("FAIL impulse_prefix: got %b expected %b", g14, pat); end
        checks++;
        if (got_block(0) !== ref_encode(b))
            begin failures++; $display("FAIL impulse_block: got %h expected %h", got_block(0), ref_encode(b)); end
    endtask

    task automatic test_wrap();
        logic [95:0] b;
        logic [191:0] g;
        b = '0;
        b[95] = 1'b1;
        fork
            send_block(b);
            collect(192, 0, 1000);
        join
        g = got_block(0);
        checks++;
        if (g[191:190] !== 2'b11) begin failures++; $display("FAIL wrap_last_pair: got %b expected 11", g[191:190]); end
        checks++;
        if (g !== ref_encode(b))
            begin failures++; $display("FAIL wrap_block: got %h expected %h", g, ref_encode(b)); end
    endtask

    task automatic test_backpressure();
        logic [95:0] b;
        b = '0;
        b[0] = 1'b1;
        fork
            send_block(b);
            collect(192, 1, 3000);
        join
        checks++;
        if (got_block(0) !== ref_encode(b))
            begin failures++; $display("FAIL backpressure_block: got %h expected %h", got_block(0), ref_encode(b)); end
        checks++;
        if (stall_bad != 0) begin failures++; $display("FAIL backpressure_hold: %0d unstable stalls, expected 0", stall_bad); end
    endtask

    task automatic test_random();
        logic [95:0] b;
        for (int r = 0; r < 2; r++) begin
            b = rand_block();
            fork
                send_block(b);
                collect(192, 2, 3000);
            join
            checks++;
            if (got_block(0) !== ref_encode(b))
                begin failures++; $display("FAIL random_block%0d: got %h expected %h", r, got_block(0), ref_encode(b)); end
            checks++;
            if (stall_bad != 0) begin failures++; $display("FAIL random_hold%0d: %0d unstable stalls, expected 0", r, stall_bad); end
        end
    endtask

    task automatic test_back_to_back();
        logic [95:0] blk [3];
        for (int j = 0; j < 3; j++) blk[j] = rand_block();
        acc_cyc.delete();
        stalled = 1'b0;
        fork
            begin
                send_block(blk[0]);
                send_block(blk[1]);
                send_block(blk[2]);
            end
            collect(576, 0, 3000);
        join
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (got_block(192*j) !== ref_encode(blk[j]))
                begin failures++; $display("FAIL b2b_block%0d: got %h expected %h", j, got_block(192*j), ref_encode(blk[j])); end
        end
        checks++;
        if (stalled !== 1'b1) begin failures++; $display("FAIL b2b_ready_drop: stalled=%b expected 1", stalled); end
        checks++;
        if (acc_cyc.size() != 288 || acc_cyc[191] - acc_cyc[0] != 191)
            begin failures++; $display("FAIL b2b_fill_two: first two blocks not accepted back to back (n=%0d)", acc_cyc.size()); end
        checks++;
        if (tcyc.size() != 576 || tcyc[192] - tcyc[191] != 3)
            begin failures++; $display("FAIL b2b_gap: spacing %0d expected 3", tcyc.size() == 576 ? tcyc[192] - tcyc[191] : -1); end
        checks++;
        if (acc_cyc.size() != 288 || tcyc.size() != 576 || acc_cyc[192] != tcyc[191] + 2)
            begin failures++; $display("FAIL b2b_ready_rise: block3 start %0d expected %0d",
                acc_cyc.size() == 288 ? acc_cyc[192] : -1, tcyc.size() == 576 ? tcyc[191] + 2 : -1); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] b;
        b = '0;
        b[0] = 1'b1;
        fork
            begin
                send_block(rand_block());
                send_block(rand_block());
            end
            collect(50, 0, 1000);
        join
        reset_N = 1'b0;
        #2;
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL midreset_valid_out: got %b expected 0", valid_out); end
        checks++;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL midreset_ready_out: got %b expected 0", ready_out); end
        @(negedge clk);
        reset_N = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc.delete();
        fork
            send_block(b);
            collect(192, 0, 1000);
        join
        checks++;
        if (got_block(0) !== ref_encode(b))
            begin failures++; $display("FAIL midreset_block: got %h expected %h", got_block(0), ref_encode(b)); end
        checks++;
        if (acc_cyc.size() != 96 || first_valid != acc_cyc[95] + 2)
            begin failures++; $display("FAIL midreset_latency: valid at cycle %0d expected %0d", first_valid, acc_cyc.size() == 96 ? acc_cyc[95] + 2 : -1); end
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_impulse();
        test_wrap();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
